// File: rtl/cdb_arbiter.sv
//==============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter granting BUS_CNT common data bus lanes among
//            REQ_CNT execution-unit requesters; lanes broadcast one cycle
//            after the combinational grant. Optional macro CDB_STATS_EN adds
//            grant and stall counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int XLEN    = 32,
  parameter int REQ_CNT = 4,
  parameter int BUS_CNT = 2,
  parameter int TAG_W   = 6,
  localparam int SRC_W  = $clog2(REQ_CNT)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [REQ_CNT-1:0]                req,
  input  logic [REQ_CNT-1:0][XLEN-1:0]      req_data,
  input  logic [REQ_CNT-1:0][TAG_W-1:0]     req_tag,
  output logic [REQ_CNT-1:0]                gnt,
  output logic [BUS_CNT-1:0]                cdb_valid,
  output logic [BUS_CNT-1:0][XLEN-1:0]      cdb_data,
  output logic [BUS_CNT-1:0][TAG_W-1:0]     cdb_tag,
  output logic [BUS_CNT-1:0][SRC_W-1:0]     cdb_src,
  output logic [REQ_CNT-1:0][31:0]          stat_grants,
  output logic [31:0]                       stat_stalls
);

  localparam int             PW     = $clog2(REQ_CNT + 1);
  localparam logic [PW-1:0]  BUS_PW = PW'(BUS_CNT);
  localparam logic [SRC_W:0] REQ_W1 = (SRC_W + 1)'(REQ_CNT);

  logic [SRC_W-1:0]                ptr;
  logic [SRC_W-1:0]                nxt_ptr;
  logic [REQ_CNT-1:0]              rot;
  logic [REQ_CNT-1:0]              gnt_rot;
  logic [BUS_CNT-1:0]              lane_vld;
  logic [BUS_CNT-1:0][SRC_W-1:0]   lane_src;
  logic [BUS_CNT-1:0][XLEN-1:0]    lane_data;
  logic [BUS_CNT-1:0][TAG_W-1:0]   lane_tag;

  // Requests are rotated so that position 0 is the current pointer; the
  // scan then walks constant positions and lanes fill in scan order.
  always_comb begin : grant_select
    logic [PW-1:0]    run;
    logic [SRC_W:0]   pos;
    logic [SRC_W:0]   nxt;
    logic [SRC_W-1:0] last;
    rot      = REQ_CNT'({req, req} >> ptr);
    gnt_rot  = '0;
    lane_vld = '0;
    lane_src = '0;
    run      = '0;
    pos      = '0;
    last     = ptr;
    if (reset && !flush) begin
      for (int off = 0; off < REQ_CNT; off++) begin
        pos = {1'b0, ptr} + (SRC_W + 1)'(off);
        if (pos >= REQ_W1) pos = pos - REQ_W1;
        if (rot[off] && (run < BUS_PW)) begin
          gnt_rot[off] = 1'b1;
          for (int k = 0; k < BUS_CNT; k++) begin
            if (run == PW'(k)) begin
              lane_vld[k] = 1'b1;
              lane_src[k] = pos[SRC_W-1:0];
            end
          end
          last = pos[SRC_W-1:0];
          run  = run + PW'(1);
        end
      end
    end
    gnt = REQ_CNT'(({gnt_rot, gnt_rot} << ptr) >> REQ_CNT);
    nxt = {1'b0, last} + (SRC_W + 1)'(1);
    if (nxt >= REQ_W1) nxt = '0;
    nxt_ptr = (|gnt_rot) ? nxt[SRC_W-1:0] : ptr;
  end

  always_comb begin : lane_mux
    lane_data = '0;
    lane_tag  = '0;
    for (int k = 0; k < BUS_CNT; k++) begin
      for (int j = 0; j < REQ_CNT; j++) begin
        if (lane_src[k] == SRC_W'(j)) begin
          lane_data[k] = req_data[j];
          lane_tag[k]  = req_tag[j];
        end
      end
    end
  end

  // Idle lanes keep their last payload; only the valid bit drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      cdb_valid <= '0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
    end else begin
      ptr       <= nxt_ptr;
      cdb_valid <= lane_vld;
      for (int k = 0; k < BUS_CNT; k++) begin
        if (lane_vld[k]) begin
          cdb_data[k] <= lane_data[k];
          cdb_tag[k]  <= lane_tag[k];
          cdb_src[k]  <= lane_src[k];
        end
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [REQ_CNT-1:0][31:0] grant_cnt;
  logic [31:0]              stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_CNT; i++) begin
        grant_cnt[i] <= grant_cnt[i] + 32'(gnt[i]);
      end
      if (|(req & ~gnt)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_grants = grant_cnt;
  assign stat_stalls = stall_cnt;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//==============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed and randomized checks of cdb_arbiter against a
//            behavioural scan-order model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cdb_arbiter;
  localparam int XLEN = 32;
  localparam int R    = 4;
  localparam int B    = 2;
  localparam int TW   = 6;
  localparam int SW   = 2;
`ifdef CDB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [R-1:0]            req;
  logic [R-1:0][XLEN-1:0]  req_data;
  logic [R-1:0][TW-1:0]    req_tag;
  logic [R-1:0]            gnt;
  logic [B-1:0]            cdb_valid;
  logic [B-1:0][XLEN-1:0]  cdb_data;
  logic [B-1:0][TW-1:0]    cdb_tag;
  logic [B-1:0][SW-1:0]    cdb_src;
  logic [R-1:0][31:0]      stat_grants;
  logic [31:0]             stat_stalls;

  cdb_arbiter #(.XLEN(XLEN), .REQ_CNT(R), .BUS_CNT(B), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .req(req),
    .req_data(req_data), .req_tag(req_tag), .gnt(gnt),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .cdb_src(cdb_src), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  always #5 clock = ~clock;

  int              n_cmp = 0;
  int              n_err = 0;
  int              m_ptr;
  logic [B-1:0]    m_valid;
  logic [XLEN-1:0] m_data [B];
  logic [TW-1:0]   m_tag  [B];
  int              m_src  [B];
  logic [31:0]     m_sg   [R];
  logic [31:0]     m_ss;
  logic [R-1:0]    m_gnt;
  int              m_gsrc [B];
  int              m_gn;
  logic [R-1:0]    o_gnt;
  logic [R-1:0]    seq_gnt [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = '0; m_ss = '0;
    for (int k = 0; k < B; k++) begin m_data[k] = '0; m_tag[k] = '0; m_src[k] = 0; end
    for (int i = 0; i < R; i++) m_sg[i] = '0;
  endtask

  // Scan from the pointer; the n-th requester found takes lane n.
  task automatic model_grant();
    m_gnt = '0; m_gn = 0;
    if (reset && !flush) begin
      for (int i = 0; i < R; i++) begin
        int idx;
        idx = (m_ptr + i) % R;
        if (req[idx] && m_gn < B) begin
          m_gnt[idx] = 1'b1; m_gsrc[m_gn] = idx; m_gn++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    for (int k = 0; k < B; k++) begin
      chk($sformatf("cdb_data[%0d]", k), 64'(cdb_data[k]), 64'(m_data[k]));
      chk($sformatf("cdb_tag[%0d]", k), 64'(cdb_tag[k]), 64'(m_tag[k]));
      chk($sformatf("cdb_src[%0d]", k), 64'(cdb_src[k]), 64'(m_src[k]));
    end
    for (int i = 0; i < R; i++)
      chk($sformatf("stat_grants[%0d]", i), 64'(stat_grants[i]), STATS ? 64'(m_sg[i]) : 64'd0);
    chk("stat_stalls", 64'(stat_stalls), STATS ? 64'(m_ss) : 64'd0);
  endtask

  task automatic step(input logic fl);
    flush = fl;
    #1;
    model_grant();
    o_gnt = gnt;
    check_outputs();
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < B; k++) begin
        if (k < m_gn) begin
          m_valid[k] = 1'b1;
          m_data[k]  = req_data[m_gsrc[k]];
          m_tag[k]   = req_tag[m_gsrc[k]];
          m_src[k]   = m_gsrc[k];
        end else begin
          m_valid[k] = 1'b0;
        end
      end
      if (m_gn > 0) m_ptr = (m_gsrc[m_gn-1] + 1) % R;
      for (int i = 0; i < R; i++) if (m_gnt[i]) m_sg[i] = m_sg[i] + 32'd1;
      if (|(req & ~m_gnt)) m_ss = m_ss + 32'd1;
    end
    @(negedge clock);
  endtask

  task automatic new_result(input int i);
    req[i]      = 1'b1;
    req_data[i] = $urandom;
    req_tag[i]  = TW'($urandom);
  endtask

  task automatic renew_granted();
    for (int i = 0; i < R; i++) if (m_gnt[i]) new_result(i);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req = '0; req_data = '0; req_tag = '0;
    model_reset();
    for (int i = 0; i < R; i++) new_result(i);
    repeat (2) @(negedge clock);
    #1;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_data", 64'(cdb_data), 64'd0);
    chk("reset_tag", 64'(cdb_tag), 64'd0);
    chk("reset_src", 64'(cdb_src), 64'd0);
    chk("reset_stalls", 64'(stat_stalls), 64'd0);
    @(negedge clock);
    req = '0; reset = 1'b1;

    // Single requester from ptr 0
    new_result(2);
    step(1'b0);
    chk("single_gnt", 64'(o_gnt), 64'b0100);
    chk("single_valid", 64'(cdb_valid), 64'b01);
    chk("single_src", 64'(cdb_src[0]), 64'd2);
    chk("single_data", 64'(cdb_data[0]), 64'(req_data[2]));
    req = '0;

    // Wrap from ptr 3
    new_result(0); new_result(3);
    step(1'b0);
    chk("wrap_gnt", 64'(o_gnt), 64'b1001);
    chk("wrap_src0", 64'(cdb_src[0]), 64'd3);
    chk("wrap_src1", 64'(cdb_src[1]), 64'd0);
    req = '0;

    // Flush with all requesting, then resume from ptr 1
    for (int i = 0; i < R; i++) new_result(i);
    step(1'b1);
    chk("flush_gnt", 64'(o_gnt), 64'd0);
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    step(1'b0);
    chk("resume_gnt", 64'(o_gnt), 64'b0110);
    renew_granted();
    step(1'b0);
    chk("resume_gnt2", 64'(o_gnt), 64'b1001);
    renew_granted();

    // Randomized traffic with occasional flush
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < R; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) new_result(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 1) == 1) begin
          new_result(i);
        end
      end
      step($urandom_range(0, 9) == 0);
    end

    // Async reset while both lanes are broadcasting
    for (int i = 0; i < R; i++) if (!req[i] || m_gnt[i]) new_result(i);
    step(1'b0);
    renew_granted();
    step(1'b0);
    chk("pre_reset_valid", 64'(cdb_valid), 64'b11);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 64'(cdb_valid), 64'd0);
    chk("async_gnt", 64'(gnt), 64'd0);
    chk("async_data", 64'(cdb_data), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < R; i++) new_result(i);
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      seq_gnt[c] = o_gnt;
      renew_granted();
    end
    chk("all_gnt0", 64'(seq_gnt[0]), 64'b0011);
    chk("all_gnt1", 64'(seq_gnt[1]), 64'b1100);
    chk("all_gnt2", 64'(seq_gnt[2]), 64'b0011);
    #1;
    for (int i = 0; i < R; i++)
      chk($sformatf("stats_grants[%0d]", i), 64'(stat_grants[i]), STATS ? 64'd2 : 64'd0);
    chk("stats_stalls", 64'(stat_stalls), STATS ? 64'd4 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter sharing BUS_CNT common data bus (CDB) lanes among REQ_CNT execution-unit requesters (alu, branch, load_store, mult_div).
- Sits between the execution stations fed by the issuer and the CDB consumers: ROB, reservation stations and register file.
- Grants are combinational in the request cycle. CDB outputs are registered, so results broadcast one cycle after grant.

Parameters:
- XLEN, 32, result data width.
- REQ_CNT, 4, number of requesters; index 0=AL, 1=BR, 2=LS, 3=MD; legal range 2..8.
- BUS_CNT, 2, number of CDB lanes; legal range 1..REQ_CNT.
- TAG_W, 6, rename tag width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (mispredict).
- req  in  REQ_CNT  per-requester result-ready.
- req_data  in  REQ_CNT x XLEN  per-requester result.
- req_tag  in  REQ_CNT x TAG_W  per-requester destination tag.
- gnt  out  REQ_CNT  per-requester grant, combinational.
- cdb_valid  out  BUS_CNT  lane carries a result.
- cdb_data  out  BUS_CNT x XLEN  lane result.
- cdb_tag  out  BUS_CNT x TAG_W  lane tag.
- cdb_src  out  BUS_CNT x $clog2(REQ_CNT)  granted requester index.
- stat_grants  out  REQ_CNT x 32  grant counters (optional feature).
- stat_stalls  out  32  denied-request cycle counter (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - cdb_valid, cdb_data, cdb_tag, cdb_src all 0.
  - Round-robin pointer ptr=0.
  - Stat counters 0.
- gnt is combinational and is 0 while reset is asserted.
- Request handshake: a requester holds req, req_data and req_tag stable until it sees gnt=1 in the same cycle. It may present a new result the following cycle.
- Grant selection each cycle:
  - Scan indices ptr, ptr+1, ... mod REQ_CNT.
  - The first requesting index goes to lane 0, the second to lane 1, and so on, up to BUS_CNT grants.
  - At most one lane per requester per cycle.
  - Lanes are filled densely: lane k is valid only if lanes 0..k-1 are valid.
- Latency:
  - On the clock edge ending a grant cycle, lane k registers cdb_valid=1 plus the data, tag and source index of its granted requester.
  - Unused lanes register cdb_valid=0; their data, tag and src hold previous values.
  - With no requests, all cdb_valid=0 next cycle.
- Pointer update:
  - If at least one grant was issued, ptr <= (highest-lane granted index + 1) mod REQ_CNT.
  - Otherwise ptr is unchanged.
  - Wrap-around from REQ_CNT-1 to 0 is required.
- Fairness: with all REQ_CNT requesting continuously, each requester is granted within ceil(REQ_CNT/BUS_CNT) cycles.
- Flush:
  - gnt forced to 0 that cycle.
  - cdb_valid cleared on the next edge.
  - ptr unchanged.
  - Requesters keep or drop req per their own flush logic.
  - Flush in the same cycle as requests: no grant, no broadcast.
- Reset mid-operation: asynchronous clear of all state; an in-flight broadcast is lost.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined:
  - stat_grants[i] increments by 1 on each edge where gnt[i]=1.
  - stat_stalls increments by 1 on each edge where at least one req=1 with gnt=0 (flush cycles included).
  - All counters wrap at 2^32 and clear on reset.
- Undefined: stat_grants and stat_stalls are tied to 0 and no counter flops are synthesized.

Test Plan:
- Single requester: req=0100, ptr=0 -> gnt=0100; next cycle cdb_valid=01, cdb_src[0]=2, data/tag match; ptr becomes 3.
- All requesting from reset: req=1111 held -> gnt sequence 0011, 1100, 0011; cdb_src lanes (0,1), (2,3), (0,1); ptr sequence 0, 2, 0.
- Wrap: ptr=3, req=1001 -> gnt=1001; lane0 src=3, lane1 src=0; ptr becomes 1.
- Idle and flush: req=1111 with flush=1 -> gnt=0000, cdb_valid=00 next cycle, ptr unchanged; after flush deasserts, grants resume from the same ptr.
- Async reset mid-stream: assert reset between edges while cdb_valid=11 -> cdb_valid=00 immediately, ptr=0, gnt=0; release -> req=1111 grants 0011.
- CDB_STATS_EN: req=1111 for 4 cycles -> stat_grants={2,2,2,2}, stat_stalls=4; without the macro both read 0.
